rab_l2_inv_walker: RTL and testbench
====================================

Name: rab_l2_inv_walker

Overview:
- Invalidation engine for the RAB L2 TLB, upstream of the L2 tag RAM.
- The config slave captures an invalidation range from writes to 0x10 (start VA) and 0x18 (end VA) and hands it to this block as one request.
- The block walks every L2 tag entry, reads its VPN and valid bit, and clears the valid bit of each entry whose page lies inside the range.
- busy_o stalls L2 lookups and config writes to the tag RAM while a walk is in progress.

Parameters:
- AW, 32, virtual address width
- PAGE_SIZE_LOG2, 12, log2 of page size in bytes
- N_SETS, 32, number of L2 sets (power of two)
- N_SET_ENTRIES, 32, entries per set (power of two)
- N (derived), N_SETS*N_SET_ENTRIES; IDXW = clog2(N); VPNW = AW-PAGE_SIZE_LOG2

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- inv_req_i  in  1  invalidation request valid
- inv_ready_o  out  1  block can accept a request
- inv_addr_start_i  in  AW  first VA of range (inclusive)
- inv_addr_end_i  in  AW  last VA of range (inclusive)
- busy_o  out  1  walk in progress; L2 lookups and config tag writes must stall
- done_o  out  1  one-cycle pulse when the request has completed
- n_inv_o  out  IDXW+1  entries invalidated by the last request; held until the next accept
- tag_rd_en_o  out  1  tag RAM read strobe
- tag_rd_addr_o  out  IDXW  read index, equal to set*N_SET_ENTRIES+entry
- tag_rd_vpn_i  in  VPNW  stored VPN, valid the cycle after tag_rd_en_o
- tag_rd_valid_i  in  1  stored valid bit, valid the cycle after tag_rd_en_o
- tag_wr_en_o  out  1  clear the valid bit at tag_wr_addr_o (no other field is written)
- tag_wr_addr_o  out  IDXW  clear index

Behaviour:
- Reset values: clk_i is the single clock. rst_ni is asynchronous and active-low. In reset, state=IDLE, inv_ready_o=1, busy_o=0, done_o=0, n_inv_o=0, tag_rd_en_o=0, tag_wr_en_o=0, and all address outputs are 0.
- Reset mid-walk aborts immediately. Entries already cleared stay cleared. No further writes are issued.
- Handshake: a request is accepted on a rising edge with inv_req_i&inv_ready_o. inv_ready_o=1 only in IDLE. Inputs are latched at accept and need not be held afterwards.
- Range latching: vpn_lo=start>>PAGE_SIZE_LOG2 and vpn_hi=end>>PAGE_SIZE_LOG2. The comparison is unsigned on VPNW bits.
- FSM states: IDLE, WALK, DRAIN, DONE.
- IDLE -> WALK on accept when start<=end; idx=0 and n_inv=0.
- IDLE -> DONE on accept when end<start. No RAM access is made and n_inv_o=0.
- WALK: tag_rd_en_o=1 and tag_rd_addr_o=idx every cycle, then idx++. After idx==N-1 is issued, go to DRAIN.
- Compare stage (registered): one cycle after each read, if tag_rd_valid_i && vpn_lo<=tag_rd_vpn_i<=vpn_hi, then tag_wr_en_o=1, tag_wr_addr_o is the read index delayed by one cycle, and n_inv increments. Otherwise tag_wr_en_o=0.
- DRAIN: one cycle, no read; this is the compare for the last index. Then go to DONE.
- DONE: done_o=1 for one cycle, busy_o=0, then go to IDLE.
- busy_o=1 in WALK and DRAIN.
- Latency: accept at edge 0. Reads occur in cycles 1..N, writes in cycles 2..N+1, done_o in cycle N+2, and inv_ready_o rises in cycle N+3. For an inverted range, done_o is in cycle 1.
- Read and write ports are independent. A write to index k in the same cycle as a read of index k+1 is legal.
- Partial overlap: a range covering only part of a page invalidates the whole page.
- Boundary values: start=0 and end=2^AW-1 invalidate every valid entry. n_inv_o saturates naturally at N, because IDXW+1 bits cannot overflow.
- inv_req_i while busy is ignored, since ready=0. It is not queued.

Test Plan:
- Test parameters: N_SETS=4, N_SET_ENTRIES=2, so N=8.
- Full-range request: all 8 entries valid with VPNs 0..7; request start=0x0000, end=0x7FFF -> 8 tag_wr_en_o pulses at indices 0..7 in cycles 2..9, done_o in cycle 10, n_inv_o=8.
- Single-page request: VPN k stored at index k; request start=0x3000, end=0x3FFF -> exactly one write, at index 3, n_inv_o=1.
- Partial overlap and invalid entries: request start=0x2800, end=0x4004 with index 4 invalid -> writes at indices 2 and 3 only, n_inv_o=2.
- Inverted range: request start=0x5000, end=0x1000 -> no reads or writes, done_o in cycle 1, n_inv_o=0.
- Busy and reset interaction: assert inv_req_i during the walk -> ignored, inv_ready_o=0. Then assert rst_ni=0 at cycle 4 -> all outputs return to reset values asynchronously. After release, a new request is accepted and completes normally.
- Back-to-back requests: issue a second request in the cycle inv_ready_o rises -> it is accepted that cycle, and n_inv_o reflects only the second request when it completes.

Source files
------------

// File: rtl/rab_l2_inv_walker.sv
// rtl/rab_l2_inv_walker.sv - RAB L2 TLB range invalidation walker
module rab_l2_inv_walker #(
    parameter int AW             = 32,
    parameter int PAGE_SIZE_LOG2 = 12,
    parameter int N_SETS         = 32,
    parameter int N_SET_ENTRIES  = 32,
    localparam int N             = N_SETS * N_SET_ENTRIES,
    localparam int IDXW          = $clog2(N),
    localparam int VPNW          = AW - PAGE_SIZE_LOG2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inv_req_i,
    output logic            inv_ready_o,
    input  logic [AW-1:0]   inv_addr_start_i,
    input  logic [AW-1:0]   inv_addr_end_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [IDXW:0]   n_inv_o,
    output logic            tag_rd_en_o,
    output logic [IDXW-1:0] tag_rd_addr_o,
    input  logic [VPNW-1:0] tag_rd_vpn_i,
    input  logic            tag_rd_valid_i,
    output logic            tag_wr_en_o,
    output logic [IDXW-1:0] tag_wr_addr_o
);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [IDXW-1:0]   r_rd_addr;
    logic              r_cmp_vld;
    logic [IDXW-1:0]   r_cmp_idx;
    logic [VPNW-1:0]   r_vpn_lo;
    logic [VPNW-1:0]   r_vpn_hi;
    logic [IDXW:0]     r_n_inv;
    logic              w_hit;

    // Tag data arrives the cycle after the read, so the clear decision uses it directly.
    assign w_hit = r_cmp_vld && tag_rd_valid_i &&
                   (tag_rd_vpn_i >= r_vpn_lo) && (tag_rd_vpn_i <= r_vpn_hi);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_cmp_vld <= 1'b0;
            r_cmp_idx <= '0;
            r_vpn_lo  <= '0;
            r_vpn_hi  <= '0;
            r_n_inv   <= '0;
        end else begin
            r_cmp_vld <= 1'b0;
            if (w_hit) begin
                r_n_inv <= r_n_inv + (IDXW+1)'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (inv_req_i) begin
                        r_vpn_lo <= inv_addr_start_i[AW-1:PAGE_SIZE_LOG2];
                        r_vpn_hi <= inv_addr_end_i[AW-1:PAGE_SIZE_LOG2];
                        r_n_inv  <= '0;
                        r_ready  <= 1'b0;
                        if (inv_addr_start_i <= inv_addr_end_i) begin
                            r_state   <= S_WALK;
                            r_busy    <= 1'b1;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_WALK: begin
                    r_cmp_vld <= 1'b1;
                    r_cmp_idx <= r_rd_addr;
                    if (r_rd_addr == IDXW'(N-1)) begin
                        r_state   <= S_DRAIN;
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                    end else begin
                        r_rd_addr <= r_rd_addr + IDXW'(1);
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    assign inv_ready_o   = r_ready;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign n_inv_o       = r_n_inv;
    assign tag_rd_en_o   = r_rd_en;
    assign tag_rd_addr_o = r_rd_addr;
    assign tag_wr_en_o   = w_hit;
    assign tag_wr_addr_o = r_cmp_idx;

endmodule

// File: tb/tb_rab_l2_inv_walker.sv
// tb/tb_rab_l2_inv_walker.sv - scoreboard bench for rab_l2_inv_walker
module tb_rab_l2_inv_walker;

    localparam int AW   = 32;
    localparam int PGL  = 12;
    localparam int N    = 8;
    localparam int IDXW = 3;
    localparam int VPNW = AW - PGL;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            inv_req_i = 1'b0;
    logic            inv_ready_o;
    logic [AW-1:0]   inv_addr_start_i = '0;
    logic [AW-1:0]   inv_addr_end_i = '0;
    logic            busy_o;
    logic            done_o;
    logic [IDXW:0]   n_inv_o;
    logic            tag_rd_en_o;
    logic [IDXW-1:0] tag_rd_addr_o;
    logic [VPNW-1:0] tag_rd_vpn_i;
    logic            tag_rd_valid_i;
    logic            tag_wr_en_o;
    logic [IDXW-1:0] tag_wr_addr_o;

    rab_l2_inv_walker #(
        .AW(AW), .PAGE_SIZE_LOG2(PGL), .N_SETS(4), .N_SET_ENTRIES(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .inv_req_i(inv_req_i), .inv_ready_o(inv_ready_o),
        .inv_addr_start_i(inv_addr_start_i), .inv_addr_end_i(inv_addr_end_i),
        .busy_o(busy_o), .done_o(done_o), .n_inv_o(n_inv_o),
        .tag_rd_en_o(tag_rd_en_o), .tag_rd_addr_o(tag_rd_addr_o),
        .tag_rd_vpn_i(tag_rd_vpn_i), .tag_rd_valid_i(tag_rd_valid_i),
        .tag_wr_en_o(tag_wr_en_o), .tag_wr_addr_o(tag_wr_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // Tag RAM model: VPN k at index k, one-cycle read latency, valid-bit clear port.
    logic [N-1:0]    mem_valid;
    logic [VPNW-1:0] mem_vpn [N];
    logic            load_req = 1'b0;
    logic [N-1:0]    load_mask = '0;
    int              cyc = 0;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (tag_rd_en_o) begin
            tag_rd_vpn_i   <= mem_vpn[tag_rd_addr_o];
            tag_rd_valid_i <= mem_valid[tag_rd_addr_o];
        end
        if (load_req) begin
            mem_valid <= load_mask;
            for (int i = 0; i < N; i++) mem_vpn[i] <= VPNW'(i);
        end else if (tag_wr_en_o) begin
            mem_valid[tag_wr_addr_o] <= 1'b0;
        end
    end

    typedef struct { int idx; int rel; } exp_t;
    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   acc_cyc = 0;

    task automatic load_mem(input logic [N-1:0] mask);
        load_mask = mask;
        load_req  = 1'b1;
        @(posedge clk_i);
        #1 load_req = 1'b0;
    endtask

    task automatic push_exp(input logic [AW-1:0] s, input logic [AW-1:0] e, output int n);
        logic [VPNW-1:0] lo, hi;
        lo = s[AW-1:PGL];
        hi = e[AW-1:PGL];
        n  = 0;
        if (s <= e) begin
            for (int i = 0; i < N; i++) begin
                if (mem_valid[i] && mem_vpn[i] >= lo && mem_vpn[i] <= hi) begin
                    q.push_back('{idx: i, rel: i + 2});
                    n++;
                end
            end
        end
    endtask

    task automatic send(input logic [AW-1:0] s, input logic [AW-1:0] e, output int n);
        bit ok = 0;
        push_exp(s, e, n);
        inv_addr_start_i = s;
        inv_addr_end_i   = e;
        inv_req_i        = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (inv_ready_o) begin
                @(posedge clk_i);
                ok = 1;
                break;
            end
            @(negedge clk_i);
        end
        #1;
        acc_cyc          = cyc;
        inv_req_i        = 1'b0;
        inv_addr_start_i = $urandom;
        inv_addr_end_i   = $urandom;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL accept: request not accepted within budget");
        end
    endtask

    task automatic check_write();
        exp_t x;
        checks++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: idx %0d cycle %0d, none expected", tag_wr_addr_o, cyc - acc_cyc + 1);
        end else begin
            x = q.pop_front();
            if (tag_wr_addr_o !== IDXW'(x.idx) || (cyc - acc_cyc + 1) != x.rel) begin
                fails++;
                $display("FAIL write: idx %0d cycle %0d, expected idx %0d cycle %0d",
                         tag_wr_addr_o, cyc - acc_cyc + 1, x.idx, x.rel);
            end
        end
    endtask

    task automatic wait_done(input int exp_n, input int exp_lat, input int exp_rd);
        bit got = 0;
        int rd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (tag_rd_en_o) begin
                checks++;
                if (tag_rd_addr_o !== IDXW'(rd)) begin
                    fails++;
                    $display("FAIL rd_addr: got %0d expected %0d", tag_rd_addr_o, rd);
                end
                rd++;
            end
            if (tag_wr_en_o) check_write();
            if (done_o) begin
                got = 1;
                break;
            end
            checks++;
            if (busy_o !== (exp_rd != 0)) begin
                fails++;
                $display("FAIL busy: got %0b expected %0b", busy_o, exp_rd != 0);
            end
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL done_timeout: done_o never seen");
        end
        checks++;
        if ((cyc - acc_cyc + 1) != exp_lat) begin
            fails++;
            $display("FAIL done_cycle: got %0d expected %0d", cyc - acc_cyc + 1, exp_lat);
        end
        checks++;
        if (n_inv_o !== (IDXW+1)'(exp_n)) begin
            fails++;
            $display("FAIL n_inv: got %0d expected %0d", n_inv_o, exp_n);
        end
        checks++;
        if (rd != exp_rd || busy_o !== 1'b0 || q.size() != 0) begin
            fails++;
            $display("FAIL walk_end: reads %0d busy %0b pending %0d, expected reads %0d busy 0 pending 0",
                     rd, busy_o, q.size(), exp_rd);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || inv_ready_o !== 1'b1 || n_inv_o !== (IDXW+1)'(exp_n)) begin
            fails++;
            $display("FAIL post_done: done %0b ready %0b n_inv %0d, expected 0 1 %0d",
                     done_o, inv_ready_o, n_inv_o, exp_n);
        end
        q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (inv_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || n_inv_o !== '0 ||
            tag_rd_en_o !== 1'b0 || tag_wr_en_o !== 1'b0 || tag_rd_addr_o !== '0 || tag_wr_addr_o !== '0) begin
            fails++;
            $display("FAIL %s: ready %0b busy %0b done %0b n_inv %0d rd_en %0b wr_en %0b rd_addr %0d wr_addr %0d, expected 1 0 0 0 0 0 0 0",
                     tag, inv_ready_o, busy_o, done_o, n_inv_o, tag_rd_en_o, tag_wr_en_o, tag_rd_addr_o, tag_wr_addr_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset_asserted");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("reset_released");
    endtask

    task automatic run_case(input logic [N-1:0] mask, input logic [AW-1:0] s, input logic [AW-1:0] e);
        int n;
        load_mem(mask);
        send(s, e, n);
        if (s <= e) wait_done(n, N + 2, N);
        else        wait_done(n, 1, 0);
    endtask

    task automatic test_full_range();    run_case(8'hFF, 32'h0000_0000, 32'h0000_7FFF); endtask
    task automatic test_single_page();   run_case(8'hFF, 32'h0000_3000, 32'h0000_3FFF); endtask
    task automatic test_partial();       run_case(8'hEF, 32'h0000_2800, 32'h0000_4004); endtask
    task automatic test_inverted();      run_case(8'hFF, 32'h0000_5000, 32'h0000_1000); endtask
    task automatic test_boundary();      run_case(8'hFF, 32'h0000_0000, 32'hFFFF_FFFF); endtask

    task automatic test_busy_reset();
        int n;
        load_mem(8'hFF);
        send(32'h0, 32'h7FFF, n);
        inv_addr_start_i = 32'h5000;
        inv_addr_end_i   = 32'h1000;
        inv_req_i        = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            if (tag_wr_en_o) check_write();
            checks++;
            if (inv_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                fails++;
                $display("FAIL busy_ignore: cycle %0d ready %0b busy %0b, expected 0 1", k, inv_ready_o, busy_o);
            end
        end
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk_i);
        inv_req_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (mem_valid !== 8'hFC || q.size() != 6) begin
            fails++;
            $display("FAIL abort: valid %02h pending %0d, expected FC 6", mem_valid, q.size());
        end
        q.delete();
        rst_ni = 1'b1;
        @(negedge clk_i);
        send(32'h0, 32'h7FFF, n);
        wait_done(n, N + 2, N);
        checks++;
        if (n != 6) begin
            fails++;
            $display("FAIL after_reset_count: expected pushes %0d, required 6", n);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2, a1;
        load_mem(8'hFF);
        send(32'h3000, 32'h3FFF, n1);
        a1 = acc_cyc;
        wait_done(n1, N + 2, N);
        send(32'h0, 32'h7FFF, n2);
        checks++;
        if (acc_cyc - a1 != N + 3) begin
            fails++;
            $display("FAIL b2b_accept: second accept %0d cycles after first, expected %0d", acc_cyc - a1, N + 3);
        end
        wait_done(n2, N + 2, N);
        checks++;
        if (n_inv_o !== 4'd7) begin
            fails++;
            $display("FAIL b2b_count: n_inv %0d expected 7", n_inv_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_range();
        test_single_page();
        test_partial();
        test_inverted();
        test_boundary();
        test_busy_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
